// File: rtl/pwm_multi_shadow.sv
// Multi-channel PWM with prescaler, edge/centre alignment, per-channel polarity
// and a shadowed configuration set that is applied only at a period boundary.
module pwm_multi_shadow #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         enable,
    input  logic [PRESCALE_W-1:0]        prescale,
    input  logic [WIDTH-1:0]             period,
    input  logic                         center_mode,
    input  logic [CHANNELS*WIDTH-1:0]    duty,
    input  logic [CHANNELS-1:0]          invert,
    input  logic                         load,
    output logic                         pending,
    output logic                         period_start,
    output logic [CHANNELS-1:0]          pwm_out
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [PRESCALE_W-1:0]     r_pre_cnt;
    logic [WIDTH-1:0]          r_cnt;
    dir_t                      r_dir;
    logic                      r_period_start;
    logic [CHANNELS-1:0]       r_pwm;

    logic [WIDTH-1:0]          r_period;
    logic                      r_center;
    logic [CHANNELS*WIDTH-1:0] r_duty;
    logic [CHANNELS-1:0]       r_invert;

    logic [WIDTH-1:0]          r_period_p;
    logic                      r_center_p;
    logic [CHANNELS*WIDTH-1:0] r_duty_p;
    logic [CHANNELS-1:0]       r_invert_p;
    logic                      r_pending;

    logic                      w_tick;
    logic                      w_wrap;
    logic                      w_apply;
    logic                      w_period_zero;
    logic [WIDTH-1:0]          w_cnt_inc;
    logic [WIDTH-1:0]          w_cnt_next;
    dir_t                      w_dir_next;
    logic [CHANNELS-1:0]       w_raw;

    assign w_tick        = enable && (r_pre_cnt == prescale);
    assign w_period_zero = (r_period == '0);
    assign w_cnt_inc     = r_cnt + WIDTH'(1);

    assign w_wrap = w_tick && ((!r_center && (r_cnt == r_period))
                            || (r_center && (r_dir == DIR_DOWN) && (r_cnt == WIDTH'(1)))
                            || w_period_zero);

    // Disabling acts like a boundary: any pending set is committed at once.
    assign w_apply = r_pending && (w_wrap || !enable);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_pre_cnt <= '0;
        end else if (!enable || w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + PRESCALE_W'(1);
        end
    end

    // Direction turns down as the counter reaches the top, so the top value
    // is visited once per centre-aligned period.
    always_comb begin
        w_cnt_next = r_cnt;
        w_dir_next = r_dir;
        if (!enable || w_wrap) begin
            w_cnt_next = '0;
            w_dir_next = DIR_UP;
        end else if (w_tick) begin
            if (r_center && (r_dir == DIR_DOWN)) begin
                w_cnt_next = r_cnt - WIDTH'(1);
            end else begin
                w_cnt_next = w_cnt_inc;
                if (r_center && (w_cnt_inc >= r_period)) begin
                    w_dir_next = DIR_DOWN;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_cnt          <= '0;
            r_dir          <= DIR_UP;
            r_period_start <= 1'b0;
        end else begin
            r_cnt          <= w_cnt_next;
            r_dir          <= w_dir_next;
            r_period_start <= w_wrap;
        end
    end

    always_comb begin
        w_raw = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            w_raw[i] = (r_cnt < r_duty[i*WIDTH +: WIDTH]);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_pwm <= '0;
        end else if (!enable) begin
            r_pwm <= r_invert;
        end else begin
            r_pwm <= w_raw ^ r_invert;
        end
    end

    // A load coinciding with an apply commits the older set; the new one waits.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_period   <= '0;
            r_center   <= 1'b0;
            r_duty     <= '0;
            r_invert   <= '0;
            r_period_p <= '0;
            r_center_p <= 1'b0;
            r_duty_p   <= '0;
            r_invert_p <= '0;
            r_pending  <= 1'b0;
        end else begin
            if (w_apply) begin
                r_period <= r_period_p;
                r_center <= r_center_p;
                r_duty   <= r_duty_p;
                r_invert <= r_invert_p;
            end
            if (load) begin
                r_period_p <= period;
                r_center_p <= center_mode;
                r_duty_p   <= duty;
                r_invert_p <= invert;
                r_pending  <= 1'b1;
            end else if (w_apply) begin
                r_pending  <= 1'b0;
            end
        end
    end

    assign pending      = r_pending;
    assign period_start = r_period_start;
    assign pwm_out      = r_pwm;

endmodule
